// File: rtl/freq_gate_counter.sv
// freq_gate_counter: counts synchronised sig_in rising edges over a GATE_CYCLES clk window.
// Define FREQ_GATE_CONT_EN for continuous back-to-back windows; start is then ignored.
module freq_gate_counter #(
    parameter int unsigned GATE_CYCLES = 1000000,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] freq_cnt,
    output logic             overflow
);
    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] LOAD = GW'(GATE_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;
    state_t state, state_d;
    logic [GW-1:0] gate_cnt, gate_d;
    logic [CNT_W-1:0] edge_cnt, edge_d;
    logic [2:0] sync;
    logic ovf, ovf_d, go, rise, last;
`ifdef FREQ_GATE_CONT_EN
    logic unused_start;
    assign unused_start = start;
    assign go = 1'b1;
`else
    assign go = start;
`endif
    assign rise = sync[1] & ~sync[2];
    assign busy = state == GATE;
    assign done = state == DONE;
    always_ff @(posedge clk or posedge rst)
        if (rst) sync <= '0;
        else sync <= {sync[1:0], sig_in};
    always_comb begin
        state_d = state;
        gate_d = gate_cnt;
        edge_d = edge_cnt;
        ovf_d = ovf;
        last = 1'b0;
        case (state)
            IDLE: if (go) begin
                state_d = GATE;
                gate_d = LOAD;
                edge_d = '0;
                ovf_d = 1'b0;
            end
            GATE: begin
                gate_d = gate_cnt - 1'b1;
                if (rise) begin
                    if (&edge_cnt) ovf_d = 1'b1;
                    else edge_d = edge_cnt + 1'b1;
                end
                if (gate_cnt == '0) begin
                    state_d = DONE;
                    last = 1'b1;
                end
            end
            DONE: begin
`ifdef FREQ_GATE_CONT_EN
                state_d = GATE;
                gate_d = LOAD;
                edge_d = '0;
                ovf_d = 1'b0;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end
    // results latch on the edge into DONE so they coincide with the done strobe
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf <= 1'b0;
            freq_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_d;
            gate_cnt <= gate_d;
            edge_cnt <= edge_d;
            ovf <= ovf_d;
            if (last) begin
                freq_cnt <= edge_d;
                overflow <= ovf_d;
            end
        end
endmodule

// File: tb/tb_freq_gate_counter.sv
// tb_freq_gate_counter: scoreboard bench for single-shot measurements on a 4-bit counter.
module tb_freq_gate_counter;
    localparam int GATE = 100;
    localparam int CW = 4;
    typedef struct {int cnt; bit ovf; int cyc;} exp_t;
    logic clk = 0, rst = 1, sig_in = 0, start = 0;
    logic busy, done, overflow;
    logic [CW-1:0] freq_cnt;
    exp_t sb[$];
    int checks = 0, errors = 0, cyc = 0, ph = 0, per = 10, sig_mode = 0, run = 0;

    freq_gate_counter #(.GATE_CYCLES(GATE), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start),
        .busy(busy), .done(done), .freq_cnt(freq_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // sig_in: 0 = low, 1 = high, 2 = square wave of period per, first rise in cycle ph+1
    initial forever begin
        @(negedge clk);
        sig_in = (sig_mode == 1) ? 1'b1 :
                 (sig_mode == 2) ? (((cyc - ph - 1 + per) % per) < per / 2) : 1'b0;
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) run = 0;
        else begin
            if (busy) run++;
            if (done) begin
                if (sb.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("freq_cnt", int'(freq_cnt), e.cnt);
                    chk("overflow", int'(overflow), int'(e.ovf));
                    chk("done_cycle", cyc, e.cyc);
                    chk("busy_cycles", run, GATE);
                    chk("busy_at_done", int'(busy), 0);
                end
                run = 0;
            end
        end
    end

    task automatic measure(input int mode, input int p, input int ec, input bit eo);
        exp_t e;
        sig_mode = (mode == 1) ? 1 : 0;
        repeat (6) @(posedge clk);
        #1;
        ph = cyc;
        per = p;
        sig_mode = mode;
        start = 1;
        e.cnt = ec;
        e.ovf = eo;
        e.cyc = cyc + GATE + 1;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
        chk("done_timeout", sb.size(), 0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1 chk("idle_busy", int'(busy), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_freq_cnt"}, int'(freq_cnt), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        rst = 0;
        measure(2, 10, 10, 0); drain();
        measure(0, 10, 0, 0); drain();
        measure(1, 10, 0, 0); drain();
        measure(2, 4, 15, 1); drain();
        measure(2, 20, 5, 0); drain();
        // extra start pulses at N+10 and N+50 must be ignored
        measure(2, 10, 10, 0);
        repeat (9) @(posedge clk);
        #1 start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (39) @(posedge clk);
        #1 start = 1;
        @(posedge clk);
        #1 start = 0;
        drain();
        repeat (120) @(posedge clk);
        // reset in the middle of a window at N+40
        measure(2, 10, 10, 0);
        repeat (39) @(posedge clk);
        #1 rst = 1;
        #1 chk_zero("midreset");
        sb.delete();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        repeat (120) @(posedge clk);
        #1 chk("post_reset_busy", int'(busy), 0);
        measure(2, 10, 10, 0); drain();
        measure(2, 4, 15, 1); drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
